// File: rtl/uart_buffered_tx_pkg.sv
// Shared definitions for the buffered UART transmitter: frame FSM states and parity modes.
package uart_buffered_tx_pkg;

   localparam int unsigned PARITY_NONE   = 0;
   localparam int unsigned PARITY_EVEN   = 1;
   localparam int unsigned PARITY_ODD    = 2;
   localparam int unsigned MAX_DATAWIDTH = 9;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   // Parity bit for a zero-extended data word; zero padding leaves the XOR unchanged.
   function automatic logic parity_bit(input logic [MAX_DATAWIDTH-1:0] data,
                                       input int unsigned mode);
      return (mode == PARITY_ODD) ? ~(^data) : (^data);
   endfunction

endpackage

// File: rtl/uart_buffered_tx_fifo.sv
// Single-clock show-ahead FIFO with registered count and full/empty flags.
module uart_buffered_tx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   wr_en,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr_c;
   logic             do_rd_c;
   logic [CW-1:0]    count_nxt_c;

   assign do_wr_c = wr_en & ~full;
   assign do_rd_c = rd_en & ~empty;
   assign rd_data = mem[rd_ptr];

   always_comb begin
      count_nxt_c = count;
      case ({do_wr_c, do_rd_c})
         2'b10:   count_nxt_c = count + CW'(1);
         2'b01:   count_nxt_c = count - CW'(1);
         default: count_nxt_c = count;
      endcase
   end

   // Flags are registered from the next count so they track count exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_wr_c) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd_c) rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt_c;
         full  <= (count_nxt_c == CW'(DEPTH));
         empty <= (count_nxt_c == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr_c) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/uart_buffered_tx.sv
// FIFO-buffered UART transmitter: queues bytes and emits back-to-back LSB-first frames on txd.
module uart_buffered_tx
   import uart_buffered_tx_pkg::*;
#(
   parameter int unsigned datawidth  = 8,
   parameter int unsigned Baudrate   = 9600,
   parameter int unsigned CLK_FREQ   = 50000000,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [datawidth-1:0]        data_in,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic                        txd,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int unsigned BAUD_DIV = CLK_FREQ / Baudrate;
   localparam int unsigned CNT_W    = $clog2(BAUD_DIV);
   localparam int unsigned IDX_W    = 4;

   tx_state_t             state, state_nxt;
   logic [CNT_W-1:0]      baud_cnt, baud_cnt_nxt;
   logic [IDX_W-1:0]      bit_idx, bit_idx_nxt;
   logic [datawidth-1:0]  shreg, shreg_nxt;
   logic                  par, par_nxt;
   logic                  load_c;
   logic                  pop_c;
   logic                  bit_tick_c;
   logic                  txd_c;
   logic                  busy_c;
   logic [datawidth-1:0]  fifo_head;
   logic                  fifo_full;
   logic                  fifo_empty;

   uart_buffered_tx_fifo #(
      .WIDTH (datawidth),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_data (data_in),
      .wr_en   (in_valid),
      .rd_en   (pop_c),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign in_ready   = ~fifo_full;
   assign bit_tick_c = (baud_cnt == CNT_W'(BAUD_DIV - 1));
   assign busy_c     = (state != ST_IDLE) | (fifo_count != '0);

   // Frame sequencing; a finishing stop bit reloads straight into START when bytes are waiting.
   always_comb begin
      state_nxt    = state;
      baud_cnt_nxt = baud_cnt;
      bit_idx_nxt  = bit_idx;
      shreg_nxt    = shreg;
      par_nxt      = par;
      load_c       = 1'b0;
      txd_c        = 1'b1;

      if (state != ST_IDLE) baud_cnt_nxt = bit_tick_c ? '0 : baud_cnt + CNT_W'(1);

      case (state)
         ST_IDLE: begin
            txd_c        = 1'b1;
            baud_cnt_nxt = '0;
            if (!fifo_empty) load_c = 1'b1;
         end
         ST_START: begin
            txd_c = 1'b0;
            if (bit_tick_c) begin
               state_nxt   = ST_DATA;
               bit_idx_nxt = '0;
            end
         end
         ST_DATA: begin
            txd_c = shreg[0];
            if (bit_tick_c) begin
               shreg_nxt = shreg >> 1;
               if (bit_idx == IDX_W'(datawidth - 1)) begin
                  bit_idx_nxt = '0;
                  state_nxt   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_idx_nxt = bit_idx + IDX_W'(1);
               end
            end
         end
         ST_PARITY: begin
            txd_c = par;
            if (bit_tick_c) begin
               state_nxt   = ST_STOP;
               bit_idx_nxt = '0;
            end
         end
         ST_STOP: begin
            txd_c = 1'b1;
            if (bit_tick_c) begin
               if (bit_idx == IDX_W'(STOP_BITS - 1)) begin
                  bit_idx_nxt = '0;
                  if (!fifo_empty) load_c = 1'b1;
                  else             state_nxt = ST_IDLE;
               end else begin
                  bit_idx_nxt = bit_idx + IDX_W'(1);
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (load_c) begin
         state_nxt = ST_START;
         shreg_nxt = fifo_head;
         par_nxt   = parity_bit(MAX_DATAWIDTH'(fifo_head), PARITY);
      end
   end

   assign pop_c = load_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         par      <= 1'b0;
         txd      <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_cnt_nxt;
         bit_idx  <= bit_idx_nxt;
         shreg    <= shreg_nxt;
         par      <= par_nxt;
         txd      <= txd_c;
         busy     <= busy_c;
      end
   end

endmodule
